// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the IF/DM requesters, the shared RAM port and the arbiter.
// The slave modport is the arbiter's view; the master modport is everything around it.
interface imem_dmem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            if_req_i;
    logic [XLEN-1:0] if_addr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [XLEN-1:0] if_rdata_o;

    logic            dm_req_i;
    logic            dm_we_i;
    logic [1:0]      dm_size_i;
    logic            dm_unsigned_i;
    logic [XLEN-1:0] dm_addr_i;
    logic [XLEN-1:0] dm_wdata_i;
    logic            dm_gnt_o;
    logic            dm_rvalid_o;
    logic [XLEN-1:0] dm_rdata_o;
    logic            dm_err_o;

    logic            ram_en_o;
    logic            ram_we_o;
    logic [3:0]      ram_be_o;
    logic [XLEN-1:0] ram_addr_o;
    logic [XLEN-1:0] ram_wdata_o;
    logic [XLEN-1:0] ram_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_req_i, dm_we_i, dm_size_i, dm_unsigned_i, dm_addr_i, dm_wdata_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
        output ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_req_i, dm_we_i, dm_size_i, dm_unsigned_i, dm_addr_i, dm_wdata_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
        input  ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port big-endian word RAM between instruction fetch and data memory.
// DM has priority; a streak counter forces IF through after MAX_DM_STREAK consecutive DM wins.
module imem_dmem_arbiter #(
    parameter int XLEN          = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    imem_dmem_arbiter_if.slave   bus
);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    owner_t     r_owner;
    owner_t     w_owner_next;
    logic [3:0] r_streak;
    logic [3:0] w_streak_next;
    logic [1:0] r_size;
    logic [1:0] r_off;
    logic       r_uns;
    logic       r_err;
    logic       r_we;

    logic            w_streak_full;
    logic            w_if_win;
    logic            w_dm_win;
    logic            w_dm_misal;
    logic [1:0]      w_dm_off;
    logic [XLEN-1:0] w_if_word;
    logic [XLEN-1:0] w_dm_word;
    logic [3:0]      w_dm_be;
    logic [XLEN-1:0] w_dm_wdata;

    // ------------------------------------------------------------------
    // Arbitration (combinational in the request cycle, gated by reset)
    // ------------------------------------------------------------------
    assign w_streak_full = (r_streak == STREAK_MAX);
    assign w_if_win      = rst_n_i && bus.if_req_i && (!bus.dm_req_i || w_streak_full);
    assign w_dm_win      = rst_n_i && bus.dm_req_i && !w_if_win;

    assign w_dm_off  = bus.dm_addr_i[1:0];
    assign w_if_word = bus.if_addr_i & ~XLEN'(3);
    assign w_dm_word = {bus.dm_addr_i[XLEN-1:2], 2'b00};

    always_comb begin
        w_dm_misal = 1'b0;
        case (bus.dm_size_i)
            2'b00:   w_dm_misal = 1'b0;
            2'b01:   w_dm_misal = w_dm_off[0];
            2'b10:   w_dm_misal = |w_dm_off;
            default: w_dm_misal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Store lane steering; lane gi carries byte offset 3-gi
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE_OFF = 2'(3 - gi);
            localparam bit         LANE_HI  = (gi >= 2);
            always_comb begin
                w_dm_be[gi]            = 1'b0;
                w_dm_wdata[8*gi +: 8]  = 8'h00;
                case (bus.dm_size_i)
                    2'b00: begin
                        w_dm_be[gi]           = (w_dm_off == LANE_OFF);
                        w_dm_wdata[8*gi +: 8] = bus.dm_wdata_i[7:0];
                    end
                    2'b01: begin
                        w_dm_be[gi]           = (LANE_HI == !w_dm_off[1]);
                        w_dm_wdata[8*gi +: 8] = bus.dm_wdata_i[8*(gi % 2) +: 8];
                    end
                    default: begin
                        w_dm_be[gi]           = 1'b1;
                        w_dm_wdata[8*gi +: 8] = bus.dm_wdata_i[8*gi +: 8];
                    end
                endcase
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // RAM port: driven by the winner in its grant cycle
    // ------------------------------------------------------------------
    always_comb begin
        bus.ram_en_o    = 1'b0;
        bus.ram_we_o    = 1'b0;
        bus.ram_be_o    = 4'b0000;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        if (w_if_win) begin
            bus.ram_en_o   = 1'b1;
            bus.ram_be_o   = 4'b1111;
            bus.ram_addr_o = w_if_word;
        end else if (w_dm_win && !w_dm_misal) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_we_o    = bus.dm_we_i;
            bus.ram_be_o    = w_dm_be;
            bus.ram_addr_o  = w_dm_word;
            bus.ram_wdata_o = bus.dm_we_i ? w_dm_wdata : '0;
        end
    end

    assign bus.if_gnt_o = w_if_win;
    assign bus.dm_gnt_o = w_dm_win;

    // ------------------------------------------------------------------
    // Owner tag / streak: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_owner_next  = OWN_NONE;
        w_streak_next = r_streak;
        if (w_if_win) begin
            w_owner_next = OWN_IF;
        end else if (w_dm_win) begin
            w_owner_next = OWN_DM;
        end
        if (!bus.if_req_i || w_if_win) begin
            w_streak_next = 4'd0;
        end else if (w_dm_win && !w_streak_full) begin
            w_streak_next = r_streak + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_owner  <= OWN_NONE;
            r_streak <= 4'd0;
            r_size   <= 2'b00;
            r_off    <= 2'b00;
            r_uns    <= 1'b0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            r_owner  <= w_owner_next;
            r_streak <= w_streak_next;
            if (w_dm_win) begin
                r_size <= bus.dm_size_i;
                r_off  <= w_dm_off;
                r_uns  <= bus.dm_unsigned_i;
                r_err  <= w_dm_misal;
                r_we   <= bus.dm_we_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing and load extraction
    // ------------------------------------------------------------------
    logic [7:0]      w_rd_byte [4];
    logic [7:0]      w_ld_byte;
    logic [15:0]     w_ld_half;
    logic            w_dm_resp;
    logic            w_if_resp;
    logic [XLEN-1:0] w_ld_data;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd
            assign w_rd_byte[gi] = bus.ram_rdata_i[8*gi +: 8];
        end
    endgenerate

    // ~offset maps big-endian offset to little-endian lane index
    assign w_ld_byte = w_rd_byte[~r_off];
    assign w_ld_half = r_off[1] ? bus.ram_rdata_i[15:0] : bus.ram_rdata_i[31:16];
    assign w_if_resp = (r_owner == OWN_IF);
    assign w_dm_resp = (r_owner == OWN_DM);

    always_comb begin
        w_ld_data = bus.ram_rdata_i;
        case (r_size)
            2'b00:   w_ld_data = {{24{!r_uns && w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_data = {{16{!r_uns && w_ld_half[15]}}, w_ld_half};
            default: w_ld_data = bus.ram_rdata_i;
        endcase
    end

    assign bus.if_rvalid_o = w_if_resp;
    assign bus.if_rdata_o  = w_if_resp ? bus.ram_rdata_i : '0;
    assign bus.dm_rvalid_o = w_dm_resp;
    assign bus.dm_err_o    = w_dm_resp && r_err;
    assign bus.dm_rdata_o  = (w_dm_resp && !r_err && !r_we) ? w_ld_data : '0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: reset, fetch, sized loads/stores,
// misalignment, reset mid-access and starvation-forced fetch.
module tb_imem_dmem_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    imem_dmem_arbiter_if #(.XLEN(32)) bus ();

    imem_dmem_arbiter #(.XLEN(32), .MAX_DM_STREAK(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    // Single-port RAM model, one-cycle read latency; contents loaded while in reset
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[8'h00] <= 32'h0000_0000;
            mem[8'h10] <= 32'h1122_3344;
            mem[8'h20] <= 32'h1234_8765;
            mem[8'h40] <= 32'h0050_0093;
        end else if (bus.ram_en_o) begin
            if (bus.ram_we_o) begin
                for (int i = 0; i < 4; i++)
                    if (bus.ram_be_o[i]) mem[bus.ram_addr_o[9:2]][8*i +: 8] <= bus.ram_wdata_o[8*i +: 8];
            end else begin
                bus.ram_rdata_i <= mem[bus.ram_addr_o[9:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_if(input logic req, input logic [31:0] addr);
        bus.if_req_i  = req;
        bus.if_addr_i = addr;
    endtask

    task automatic set_dm(input logic req, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        bus.dm_req_i      = req;
        bus.dm_we_i       = we;
        bus.dm_size_i     = size;
        bus.dm_unsigned_i = uns;
        bus.dm_addr_i     = addr;
        bus.dm_wdata_i    = wdata;
    endtask

    string pat;

    initial begin
        // Reset held with both requesters active
        set_if(1'b1, 32'h0000_0103);
        set_dm(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0100, 32'h0);
        @(negedge clk); @(negedge clk); #1;
        $display("step reset-hold");
        chk("rst_if_gnt",    32'(bus.if_gnt_o),    32'd0);
        chk("rst_dm_gnt",    32'(bus.dm_gnt_o),    32'd0);
        chk("rst_ram_en",    32'(bus.ram_en_o),    32'd0);
        chk("rst_ram_addr",  bus.ram_addr_o,       32'd0);
        chk("rst_ram_be",    32'(bus.ram_be_o),    32'd0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
        chk("rst_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd0);
        chk("rst_dm_err",    32'(bus.dm_err_o),    32'd0);
        chk("rst_dm_rdata",  bus.dm_rdata_o,       32'd0);

        // Release: DM wins in the same cycle (word load of 0x100)
        @(negedge clk); rst_n = 1'b1; #1;
        $display("step release: dm word load 0x100");
        chk("rel_dm_gnt",   32'(bus.dm_gnt_o), 32'd1);
        chk("rel_if_gnt",   32'(bus.if_gnt_o), 32'd0);
        chk("rel_ram_addr", bus.ram_addr_o,    32'h100);

        // Fetch at 0x103, DM idle
        @(negedge clk); bus.dm_req_i = 1'b0; #1;
        $display("step fetch 0x103");
        chk("f_if_gnt",    32'(bus.if_gnt_o),    32'd1);
        chk("f_ram_addr",  bus.ram_addr_o,       32'h100);
        chk("f_ram_be",    32'(bus.ram_be_o),    32'hF);
        chk("f_ram_we",    32'(bus.ram_we_o),    32'd0);
        chk("ld_w_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        chk("ld_w_rdata",  bus.dm_rdata_o,       32'h0050_0093);
        chk("f_no_ifrv",   32'(bus.if_rvalid_o), 32'd0);

        // Byte store 0xAB at 0x42
        @(negedge clk);
        set_if(1'b0, 32'h0);
        set_dm(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0042, 32'h1234_56AB); #1;
        $display("step store byte 0x42");
        chk("f_if_rvalid",  32'(bus.if_rvalid_o), 32'd1);
        chk("f_if_rdata",   bus.if_rdata_o,       32'h0050_0093);
        chk("sb_dm_gnt",    32'(bus.dm_gnt_o),    32'd1);
        chk("sb_ram_we",    32'(bus.ram_we_o),    32'd1);
        chk("sb_ram_be",    32'(bus.ram_be_o),    32'b0010);
        chk("sb_ram_wdata", bus.ram_wdata_o,      32'hABAB_ABAB);
        chk("sb_ram_addr",  bus.ram_addr_o,       32'h40);

        // Signed byte load 0x42
        @(negedge clk); set_dm(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0042, 32'h0); #1;
        $display("step load sbyte 0x42");
        chk("sb_rsp_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        chk("sb_rsp_rdata",  bus.dm_rdata_o,       32'd0);
        chk("sb_rsp_err",    32'(bus.dm_err_o),    32'd0);
        chk("lb_ram_we",     32'(bus.ram_we_o),    32'd0);

        // Unsigned byte load 0x42
        @(negedge clk); set_dm(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0042, 32'h0); #1;
        $display("step load ubyte 0x42");
        chk("lb_s_rdata", bus.dm_rdata_o, 32'hFFFF_FFAB);

        // Signed half load 0x82
        @(negedge clk); set_dm(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0082, 32'h0); #1;
        $display("step load shalf 0x82");
        chk("lb_u_rdata", bus.dm_rdata_o, 32'h0000_00AB);

        // Misaligned word load 0x06
        @(negedge clk); set_dm(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0); #1;
        $display("step load word 0x06 (misaligned)");
        chk("lh_s_rdata", bus.dm_rdata_o,     32'hFFFF_8765);
        chk("mis_gnt",    32'(bus.dm_gnt_o),  32'd1);
        chk("mis_ram_en", 32'(bus.ram_en_o),  32'd0);

        // Half store 0x1234 at 0x02
        @(negedge clk); set_dm(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'hDEAD_1234); #1;
        $display("step store half 0x02");
        chk("mis_err",      32'(bus.dm_err_o),    32'd1);
        chk("mis_rvalid",   32'(bus.dm_rvalid_o), 32'd1);
        chk("mis_rdata",    bus.dm_rdata_o,       32'd0);
        chk("sh_ram_be",    32'(bus.ram_be_o),    32'b0011);
        chk("sh_ram_wdata", bus.ram_wdata_o,      32'h1234_1234);

        // Word load 0x00 sees the half store
        @(negedge clk); set_dm(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0); #1;
        $display("step load word 0x00");
        chk("sh_rsp_err", 32'(bus.dm_err_o), 32'd0);

        // Signed byte load at offset 3
        @(negedge clk); set_dm(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0043, 32'h0); #1;
        $display("step load sbyte 0x43");
        chk("lw0_rdata", bus.dm_rdata_o, 32'h0000_1234);

        @(negedge clk); bus.dm_req_i = 1'b0; #1;
        $display("step idle");
        chk("lb3_rdata",   bus.dm_rdata_o,    32'h0000_0044);
        chk("idle_gnt",    32'(bus.dm_gnt_o), 32'd0);
        chk("idle_ram_en", 32'(bus.ram_en_o), 32'd0);

        // Reset asserted after a grant, before the response edge
        @(negedge clk); set_dm(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0); #1;
        $display("step load word 0x80 then reset");
        chk("rma_gnt", 32'(bus.dm_gnt_o), 32'd1);
        #2 rst_n = 1'b0;
        @(negedge clk); bus.dm_req_i = 1'b0; rst_n = 1'b1; #1;
        chk("rma_no_rvalid", 32'(bus.dm_rvalid_o), 32'd0);
        chk("rma_no_ifrv",   32'(bus.if_rvalid_o), 32'd0);

        // Starvation: both requests held continuously
        pat = "DDDDIDDDDID";
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            set_if(1'b1, 32'h0000_0100);
            set_dm(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0); #1;
            $display("step starve cycle %0d winner %s", c, (pat[c] == "D") ? "DM" : "IF");
            chk($sformatf("st%0d_dm_gnt", c), 32'(bus.dm_gnt_o), 32'(pat[c] == "D"));
            chk($sformatf("st%0d_if_gnt", c), 32'(bus.if_gnt_o), 32'(pat[c] == "I"));
            if (c > 0) begin
                if (pat[c-1] == "D") begin
                    chk($sformatf("st%0d_dm_rdata", c), bus.dm_rdata_o, 32'h1234_8765);
                    chk($sformatf("st%0d_if_rv", c), 32'(bus.if_rvalid_o), 32'd0);
                end else begin
                    chk($sformatf("st%0d_if_rdata", c), bus.if_rdata_o, 32'h0050_0093);
                    chk($sformatf("st%0d_dm_rv", c), 32'(bus.dm_rvalid_o), 32'd0);
                end
            end
        end
        @(negedge clk); set_if(1'b0, 32'h0); bus.dm_req_i = 1'b0; #1;
        $display("step drain");
        chk("st_last_dm_rdata", bus.dm_rdata_o, 32'h1234_8765);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
